// File: rtl/stopwatch_counter.sv
// Stopwatch counter: centisecond count with run/pause/clear buttons and optional lap freeze (STOPWATCH_LAP_EN).
// Latency: a button rising edge is acted on at the clock edge where it is seen; its effect shows one cycle later.
// Backpressure: none; the buttons are debounced levels, so edges are never lost or stalled.
module stopwatch_counter #(
   parameter int CLK_HZ    = 50000000,
   parameter int TICK_HZ   = 100,
   parameter int MAX_COUNT = 36000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic [31:0] time_out,
   output logic        running,
   output logic        lap_frozen
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [31:0]   CNT_LAST   = 32'(MAX_COUNT - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [31:0]   count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          ss_prev, clr_prev;
   logic          ss_edge, clr_edge;
   logic          tick;
   logic          clear_now;
   logic          frozen_d;
   logic [31:0]   disp_d;

   assign ss_edge   = start_stop & ~ss_prev;
   assign clr_edge  = clear & ~clr_prev;
   // Clear only has effect from PAUSE, and it overrides a simultaneous start_stop.
   assign clear_now = (state_q == ST_PAUSE) && clr_edge;

   // Remember last button levels so each press is seen as a single rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_prev  <= 1'b0;
         clr_prev <= 1'b0;
      end else begin
         ss_prev  <= start_stop;
         clr_prev <= clear;
      end
   end

   // Next state, prescaler and count; the prescaler only advances on RUN cycles that stay in RUN,
   // so a pause freezes the partial tick and a fresh start waits a full DIV cycles.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      tick    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ss_edge) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (ss_edge) begin
               state_d = ST_PAUSE;
            end else if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               tick    = 1'b1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         ST_PAUSE: begin
            if (clr_edge) begin
               state_d = ST_IDLE;
               count_d = '0;
               presc_d = '0;
            end else if (ss_edge) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
         end
      endcase
      if (tick) count_d = (count_q == CNT_LAST) ? 32'd0 : count_q + 32'd1;
   end

   // Core state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         presc_q <= presc_d;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic        lap_prev;
   logic        lap_edge;
   logic        frozen_q;
   logic [31:0] snap_q, snap_d;

   assign lap_edge = lap & ~lap_prev;

   // Lap toggles the display freeze; the snapshot is the count being shown when lap was pressed.
   always_comb begin
      frozen_d = frozen_q;
      snap_d   = snap_q;
      if (clear_now) begin
         frozen_d = 1'b0;
         snap_d   = '0;
      end else if (lap_edge && (state_q != ST_IDLE)) begin
         if (frozen_q) begin
            frozen_d = 1'b0;
         end else begin
            frozen_d = 1'b1;
            snap_d   = count_q;
         end
      end
   end

   // Lap edge detector, freeze flag and snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_prev <= 1'b0;
         frozen_q <= 1'b0;
         snap_q   <= '0;
      end else begin
         lap_prev <= lap;
         frozen_q <= frozen_d;
         snap_q   <= snap_d;
      end
   end

   assign disp_d = frozen_d ? snap_d : count_d;
`else
   logic unused_lap;

   assign unused_lap = lap;
   assign frozen_d   = 1'b0;
   assign disp_d     = count_d;
`endif

   // Outputs are registered copies of the next-state values, so they line up with the state
   // and never have a combinational path from the buttons.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         time_out   <= '0;
         running    <= 1'b0;
         lap_frozen <= 1'b0;
      end else begin
         time_out   <= disp_d;
         running    <= (state_d == ST_RUN);
         lap_frozen <= frozen_d;
      end
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter (DIV=4, MAX_COUNT=10): directed scenarios plus random button traffic
// checked against a model that derives the display from total RUN cycles elapsed since clear.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_stopwatch_counter;
   localparam int CLK_HZ    = 4;
   localparam int TICK_HZ   = 1;
   localparam int MAX_COUNT = 10;
   localparam int DIV       = CLK_HZ / TICK_HZ;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_stop;
   logic        clear;
   logic        lap;
   logic [31:0] time_out;
   logic        running;
   logic        lap_frozen;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: mode 0=idle 1=run 2=pause; display = floor(run cycles / DIV) mod MAX_COUNT.
   int          m_mode;
   int unsigned m_run_cycles;
   bit          m_frozen;
   int unsigned m_snap;
   bit          p_ss, p_cl, p_lp;

   stopwatch_counter #(
      .CLK_HZ   (CLK_HZ),
      .TICK_HZ  (TICK_HZ),
      .MAX_COUNT(MAX_COUNT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_stop(start_stop),
      .clear     (clear),
      .lap       (lap),
      .time_out  (time_out),
      .running   (running),
      .lap_frozen(lap_frozen)
   );

   always #5 clk = ~clk;

   function automatic int unsigned m_count(int unsigned rc);
      return (rc / DIV) % MAX_COUNT;
   endfunction

   function int unsigned exp_time();
      return m_frozen ? m_snap : m_count(m_run_cycles);
   endfunction

   function bit exp_run();
      return (m_mode == 1);
   endfunction

   task model_reset();
      m_mode       = 0;
      m_run_cycles = 0;
      m_frozen     = 0;
      m_snap       = 0;
      p_ss         = 0;
      p_cl         = 0;
      p_lp         = 0;
   endtask

   // Drive one cycle of button levels, advance the model at the rising edge, return at the falling edge.
   task step(input bit ss, input bit cl, input bit lp);
      bit          ss_e, cl_e, lp_e;
      int          old_mode;
      int unsigned old_cnt;
      start_stop = ss;
      clear      = cl;
      lap        = lp;
      @(posedge clk);
      ss_e = ss && !p_ss;
      cl_e = cl && !p_cl;
      lp_e = lp && !p_lp;
      p_ss = ss;
      p_cl = cl;
      p_lp = lp;
      old_mode = m_mode;
      old_cnt  = m_count(m_run_cycles);
      if (m_mode == 0) begin
         if (ss_e) m_mode = 1;
      end else if (m_mode == 1) begin
         if (ss_e) m_mode = 2;
         else m_run_cycles++;
      end else begin
         if (cl_e) begin
            m_mode = 0;
            m_run_cycles = 0;
            m_frozen = 0;
            m_snap = 0;
         end else if (ss_e) begin
            m_mode = 1;
         end
      end
`ifdef STOPWATCH_LAP_EN
      if (lp_e && old_mode != 0 && !(old_mode == 2 && cl_e)) begin
         if (m_frozen) begin
            m_frozen = 0;
         end else begin
            m_frozen = 1;
            m_snap   = old_cnt;
         end
      end
`else
      if (lp_e && old_mode < 0) m_snap = old_cnt;
`endif
      @(negedge clk);
   endtask

   task go_idle();
      step(0, 0, 0);
      if (m_mode == 1) step(1, 0, 0);
      step(0, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);
   endtask

   task test_reset();
      rst = 1'b1;
      start_stop = 1'b0;
      clear = 1'b0;
      lap = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if (time_out !== 32'd0) begin n_bad++; $display("FAIL reset_time: got %0d want 0", time_out); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
      n_cmp++; if (lap_frozen !== 1'b0) begin n_bad++; $display("FAIL reset_frozen: got %b want 0", lap_frozen); end
      rst = 1'b0;
      step(0, 0, 0);
      n_cmp++; if (time_out !== 32'd0 || running !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: got t=%0d r=%b want t=0 r=0", time_out, running); end
   endtask

   task test_run_pause();
      step(1, 0, 0);
      n_cmp++; if (running !== 1'b1 || time_out !== 32'd0) begin n_bad++; $display("FAIL start_edge: got r=%b t=%0d want r=1 t=0", running, time_out); end
      for (int i = 0; i < 22; i++) begin
         step(0, 0, 0);
         n_cmp++; if (time_out !== exp_time()) begin n_bad++; $display("FAIL run_time cyc %0d: got %0d want %0d", i, time_out, exp_time()); end
         if (i == 19) begin
            n_cmp++; if (time_out !== 32'd5) begin n_bad++; $display("FAIL run_20: got %0d want 5", time_out); end
         end
      end
      step(1, 0, 0);
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0);
         n_cmp++; if (time_out !== 32'd5 || running !== 1'b0) begin n_bad++; $display("FAIL paused cyc %0d: got t=%0d r=%b want t=5 r=0", i, time_out, running); end
      end
      step(1, 0, 0);
      n_cmp++; if (time_out !== 32'd5 || running !== 1'b1) begin n_bad++; $display("FAIL resume: got t=%0d r=%b want t=5 r=1", time_out, running); end
      step(0, 0, 0);
      n_cmp++; if (time_out !== 32'd5) begin n_bad++; $display("FAIL resume_1: got %0d want 5", time_out); end
      step(0, 0, 0);
      n_cmp++; if (time_out !== 32'd6) begin n_bad++; $display("FAIL resume_2: got %0d want 6", time_out); end
   endtask

   task test_clear();
      step(0, 1, 0);
      n_cmp++; if (running !== 1'b1 || time_out !== exp_time()) begin n_bad++; $display("FAIL clear_in_run: got r=%b t=%0d want r=1 t=%0d", running, time_out, exp_time()); end
      step(0, 0, 0);
      step(1, 0, 0);
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL pause_before_clear: got r=%b want 0", running); end
      step(0, 0, 0);
      step(1, 1, 0);
      n_cmp++; if (running !== 1'b0 || time_out !== 32'd0) begin n_bad++; $display("FAIL clear_wins: got r=%b t=%0d want r=0 t=0", running, time_out); end
      step(0, 0, 0);
      step(0, 1, 0);
      n_cmp++; if (running !== 1'b0 || time_out !== 32'd0) begin n_bad++; $display("FAIL clear_in_idle: got r=%b t=%0d want r=0 t=0", running, time_out); end
   endtask

   task test_wrap();
      int unsigned want;
      step(0, 0, 0);
      step(1, 0, 0);
      for (int k = 1; k <= 44; k++) begin
         step(0, 0, 0);
         want = (k / DIV) % MAX_COUNT;
         n_cmp++; if (time_out !== want || running !== 1'b1) begin n_bad++; $display("FAIL wrap cyc %0d: got t=%0d r=%b want t=%0d r=1", k, time_out, running, want); end
      end
   endtask

   task test_lap();
      go_idle();
      step(1, 0, 0);
      repeat (12) step(0, 0, 0);
      step(0, 0, 1);
`ifdef STOPWATCH_LAP_EN
      n_cmp++; if (time_out !== 32'd3 || lap_frozen !== 1'b1) begin n_bad++; $display("FAIL lap_capture: got t=%0d f=%b want t=3 f=1", time_out, lap_frozen); end
`else
      n_cmp++; if (time_out !== 32'd3 || lap_frozen !== 1'b0) begin n_bad++; $display("FAIL lap_disabled: got t=%0d f=%b want t=3 f=0", time_out, lap_frozen); end
`endif
      for (int i = 0; i < 15; i++) begin
         step(0, 0, 0);
         n_cmp++; if (time_out !== exp_time() || lap_frozen !== m_frozen) begin n_bad++; $display("FAIL lap_hold cyc %0d: got t=%0d f=%b want t=%0d f=%b", i, time_out, lap_frozen, exp_time(), m_frozen); end
      end
      step(0, 0, 1);
      n_cmp++; if (time_out !== 32'd7 || lap_frozen !== 1'b0) begin n_bad++; $display("FAIL lap_release: got t=%0d f=%b want t=7 f=0", time_out, lap_frozen); end
   endtask

   task test_reset_mid();
      step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (time_out !== 32'd0 || running !== 1'b0 || lap_frozen !== 1'b0) begin n_bad++; $display("FAIL async_reset: got t=%0d r=%b f=%b want 0 0 0", time_out, running, lap_frozen); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(0, 0, 0);
      n_cmp++; if (time_out !== 32'd0 || running !== 1'b0) begin n_bad++; $display("FAIL after_reset: got t=%0d r=%b want 0 0", time_out, running); end
      step(1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0);
         n_cmp++; if (time_out !== exp_time() || running !== 1'b1) begin n_bad++; $display("FAIL restart cyc %0d: got t=%0d r=%b want t=%0d r=1", i, time_out, running, exp_time()); end
      end
      n_cmp++; if (time_out !== 32'd1) begin n_bad++; $display("FAIL restart_from_zero: got %0d want 1", time_out); end
   endtask

   task test_random();
      bit ss, cl, lp;
      for (int i = 0; i < 600; i++) begin
         ss = ($urandom_range(0, 11) == 0);
         cl = ($urandom_range(0, 7) == 0);
         lp = ($urandom_range(0, 9) == 0);
         step(ss, cl, lp);
         n_cmp++;
         if (time_out !== exp_time() || running !== exp_run() || lap_frozen !== m_frozen) begin
            n_bad++;
            $display("FAIL random cyc %0d: got t=%0d r=%b f=%b want t=%0d r=%b f=%b",
                     i, time_out, running, lap_frozen, exp_time(), exp_run(), m_frozen);
         end
      end
   endtask

   initial begin
      test_reset();
      test_run_pause();
      test_clear();
      test_wrap();
      test_lap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
